// File: rtl/alu_nibble_serial.sv
// Nibble-serial ALU: one 4-bit digit per enabled cycle, LSB first, with
// per-digit decimal correction for add/subtract and a start/busy/done handshake.
//
// state  | meaning
// S_IDLE | waiting for start; OUT/flags hold last result
// S_RUN  | processing nibble cnt, completes on cnt == NIB-1
module alu_nibble_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             RDY,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             right,
  input  logic [WIDTH-1:0] AI,
  input  logic [WIDTH-1:0] BI,
  input  logic             CI,
  input  logic             BCD,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT,
  output logic             CO,
  output logic             V,
  output logic             Z,
  output logic             N,
  output logic             HC
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_r, res_nxt;
  logic [3:0]       op_r;
  logic             right_r, bcd_r, carry_r, hc_r;
  logic             last, arith;
  logic [3:0]       a_n, b_n, bp, nib_a, nib;
  logic [4:0]       s;
  logic             cn, v_nib;

  assign last    = (state == S_RUN) && (cnt == CW'(NIB - 1));
  assign arith   = !right_r && (op_r == 4'b0011 || op_r == 4'b0111 || op_r == 4'b1011);
  assign res_nxt = {nib, res_r[WIDTH-1:4]};

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= S_IDLE;
    else if (RDY)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  // Current digit: operands are shifted right so nibble 0 always holds the active digit.
  always_comb begin
    a_n = a_sh[3:0];
    b_n = b_sh[3:0];
    case (op_r)
      4'b0111: bp = ~b_n;
      4'b1011: bp = a_n;
      default: bp = b_n;
    endcase
    s     = {1'b0, a_n} + {1'b0, bp} + {4'b0000, carry_r};
    nib_a = s[3:0];
    cn    = s[4];
    if (bcd_r && op_r == 4'b0011) begin
      if (s > 5'd9) begin
        nib_a = s[3:0] + 4'd6;
        cn    = 1'b1;
      end
    end else if (bcd_r && op_r == 4'b0111 && !s[4]) begin
      nib_a = s[3:0] - 4'd6;
    end
    v_nib = (a_n[3] == bp[3]) && (s[3] != a_n[3]);
    if (right_r)
      nib = a_n;
    else if (arith)
      nib = nib_a;
    else begin
      case (op_r)
        4'b1100: nib = a_n | b_n;
        4'b1101: nib = a_n & b_n;
        4'b1110: nib = a_n ^ b_n;
        default: nib = a_n;
      endcase
    end
  end

  // For shift-right the shifted operand is prepared at accept and carry holds AI[0].
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_r   <= '0;
      op_r    <= '0;
      right_r <= 1'b0;
      bcd_r   <= 1'b0;
      carry_r <= 1'b0;
      hc_r    <= 1'b0;
      done    <= 1'b0;
      OUT     <= '0;
      CO      <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b1;
      N       <= 1'b0;
      HC      <= 1'b0;
    end else if (RDY) begin
      done <= last;
      if (state == S_IDLE && start) begin
        a_sh    <= right ? {CI, AI[WIDTH-1:1]} : AI;
        b_sh    <= BI;
        op_r    <= op;
        right_r <= right;
        bcd_r   <= BCD;
        carry_r <= right ? AI[0] : CI;
        cnt     <= '0;
      end else if (state == S_RUN) begin
        a_sh  <= a_sh >> 4;
        b_sh  <= b_sh >> 4;
        res_r <= res_nxt;
        cnt   <= cnt + 1'b1;
        if (arith)
          carry_r <= cn;
        if (cnt == '0)
          hc_r <= arith && cn;
        if (last) begin
          OUT <= res_nxt;
          CO  <= arith ? cn : (right_r && carry_r);
          V   <= arith && v_nib;
          HC  <= hc_r;
          Z   <= (res_nxt == '0);
          N   <= res_nxt[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_nibble_serial.sv
// Directed bench for alu_nibble_serial (WIDTH=16): arithmetic, BCD, logic,
// shift, RDY stalls, start during RUN and mid-operation reset.
module tb_alu_nibble_serial;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n, RDY, start, right, CI, BCD;
  logic [3:0]   op;
  logic [W-1:0] AI, BI;
  logic         busy, done, CO, V, Z, N, HC;
  logic [W-1:0] OUT;

  int passed = 0;
  int total  = 0;
  int lat;

  alu_nibble_serial #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .RDY(RDY), .start(start), .op(op),
    .right(right), .AI(AI), .BI(BI), .CI(CI), .BCD(BCD),
    .busy(busy), .done(done), .OUT(OUT), .CO(CO), .V(V), .Z(Z), .N(N), .HC(HC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive operands, accept on the next edge, then scramble inputs.
  task automatic launch(input logic [3:0] o, input logic r, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic d);
    @(negedge clk);
    op = o; right = r; AI = a; BI = b; CI = c; BCD = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    AI = ~a; BI = ~b; CI = ~c; op = 4'b1100; right = ~r;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Counts edges since accept until done is seen; lat already holds edges elapsed.
  task automatic wait_done();
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  initial begin
    reset_n = 1'b0; RDY = 1'b1; start = 1'b0; right = 1'b0; CI = 1'b0; BCD = 1'b0;
    op = 4'b0011; AI = '0; BI = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  {16'b0, OUT}, 32'h0);
    check("rst_z",    {31'b0, Z}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_co",   {31'b0, CO}, 32'd0);
    reset_n = 1'b1;

    // binary add, latency
    launch(4'b0011, 1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    lat = 0; wait_done();
    check("add_lat", lat, 32'd4);
    check("add_out", {16'b0, OUT}, 32'h2201);
    check("add_flags_co_z_n_v", {28'b0, CO, Z, N, V}, 32'h0);

    // BCD add, launched back-to-back in the done cycle
    launch(4'b0011, 1'b0, 16'h0999, 16'h0001, 1'b0, 1'b1);
    check("done_cleared", {31'b0, done}, 32'd0);
    lat = 0; wait_done();
    check("b2b_lat", lat, 32'd4);
    check("bcd_add_out", {16'b0, OUT}, 32'h1000);
    check("bcd_add_hc_co", {30'b0, HC, CO}, 32'b10);
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);

    launch(4'b0011, 1'b0, 16'h9999, 16'h0001, 1'b0, 1'b1);
    lat = 0; wait_done();
    check("bcd_wrap_out", {16'b0, OUT}, 32'h0000);
    check("bcd_wrap_co_z", {30'b0, CO, Z}, 32'b11);

    launch(4'b0111, 1'b0, 16'h1000, 16'h0001, 1'b1, 1'b1);
    lat = 0; wait_done();
    check("bcd_sub_out", {16'b0, OUT}, 32'h0999);
    check("bcd_sub_co", {31'b0, CO}, 32'd1);

    launch(4'b0111, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0);
    lat = 0; wait_done();
    check("sub_out", {16'b0, OUT}, 32'hFFFF);
    check("sub_co_n", {30'b0, CO, N}, 32'b01);

    launch(4'b0011, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    lat = 0; wait_done();
    check("ovf_out", {16'b0, OUT}, 32'h8000);
    check("ovf_v_n", {30'b0, V, N}, 32'b11);

    launch(4'b0011, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b0);
    lat = 0; wait_done();
    check("ror_out", {16'b0, OUT}, 32'hC000);
    check("ror_co_v", {30'b0, CO, V}, 32'b10);

    // A+A+CI and logic ops
    launch(4'b1011, 1'b0, 16'h4321, 16'h0000, 1'b1, 1'b0);
    lat = 0; wait_done();
    check("asl_out", {16'b0, OUT}, 32'h8643);
    launch(4'b1100, 1'b0, 16'hF0F0, 16'h0F01, 1'b1, 1'b0);
    lat = 0; wait_done();
    check("or_out", {16'b0, OUT}, 32'hFFF1);
    check("or_co", {31'b0, CO}, 32'd0);
    launch(4'b1101, 1'b0, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    lat = 0; wait_done();
    check("and_out", {16'b0, OUT}, 32'h3030);
    launch(4'b1110, 1'b0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0);
    lat = 0; wait_done();
    check("xor_out_z", {15'b0, Z, OUT}, 32'h10000);
    launch(4'b1111, 1'b0, 16'h5A5A, 16'h1234, 1'b0, 1'b1);
    lat = 0; wait_done();
    check("pass_a", {16'b0, OUT}, 32'h5A5A);

    // RDY stall plus start while running
    launch(4'b0011, 1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    lat = 0;
    start = 1'b1; op = 4'b1111;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    RDY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lat += 3;
    check("stall_busy_done", {30'b0, busy, done}, 32'b10);
    RDY = 1'b1;
    wait_done();
    check("stall_lat", lat, 32'd7);
    check("stall_out", {16'b0, OUT}, 32'h2201);
    RDY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("done_held", {31'b0, done}, 32'd1);
    RDY = 1'b1;
    @(posedge clk); #1;
    check("done_release", {31'b0, done}, 32'd0);
    check("idle_after_stall", {31'b0, busy}, 32'd0);

    // reset in second RUN cycle
    launch(4'b0011, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out", {16'b0, OUT}, 32'h0);
    check("mid_rst_z_busy_done", {29'b0, Z, busy, done}, 32'b100);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_rst", {30'b0, busy, done}, 32'b00);
    launch(4'b0011, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    lat = 0; wait_done();
    check("post_rst_lat", lat, 32'd4);
    check("post_rst_out", {16'b0, OUT}, 32'h3333);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
